// File: rtl/seq_divider_pkg.sv
// Shared CPU definitions used by the sequential divider and the ALU path that selects it.
// Holds the operand width, the divider FSM encoding and the multiply/divide ALU opcodes.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int ITER_CNT_W = 6;

    localparam logic [3:0] ALU_MUL = 4'd11;
    localparam logic [3:0] ALU_DIV = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/seq_divider_twos_negate.sv
// Combinational conditional two's-complement negate: y = neg ? -a : a.
// Used for operand absolute values and for the final sign corrections.
module twos_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    always_comb begin
        y = neg ? (~a + W'(1)) : a;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider (restoring, one quotient bit per cycle) feeding LO/HI on done.
// Latency: done in the 35th cycle after acceptance, 2nd for a zero divisor; start ignored while busy.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DIV_WIDTH = seq_divider_pkg::DIV_WIDTH
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int W = DIV_WIDTH;
    localparam logic [ITER_CNT_W-1:0] CNT_LAST = ITER_CNT_W'(W - 1);

    div_state_e              state_q, state_d;
    logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]            dividend_q, dividend_d;
    logic [W-1:0]            divisor_q, divisor_d;
    logic [2*W-1:0]          rq_q, rq_d;
    logic                    q_neg_q, q_neg_d;
    logic                    r_neg_q, r_neg_d;
    logic [W-1:0]            quotient_q, quotient_d;
    logic [W-1:0]            remainder_q, remainder_d;
    logic                    dbz_q, dbz_d;

    logic [W-1:0]            dvd_abs, dvs_abs, q_fix, r_fix;
    logic [2*W-1:0]          shifted;
    logic [W-1:0]            diff;

    twos_negate #(.W(W)) u_abs_dvd (.neg(dividend_q[W-1]), .a(dividend_q), .y(dvd_abs));
    twos_negate #(.W(W)) u_abs_dvs (.neg(divisor_q[W-1]),  .a(divisor_q),  .y(dvs_abs));
    twos_negate #(.W(W)) u_fix_q   (.neg(q_neg_q), .a(rq_q[W-1:0]),   .y(q_fix));
    twos_negate #(.W(W)) u_fix_r   (.neg(r_neg_q), .a(rq_q[2*W-1:W]), .y(r_fix));

    // The partial remainder stays below the divisor (<= 2^(W-1)), so the shift never loses a bit.
    always_comb begin
        shifted = {rq_q[2*W-2:0], 1'b0};
        diff    = shifted[2*W-1:W] - divisor_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        rq_d        = rq_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    state_d    = ST_PREP;
                end
            end
            ST_PREP: begin
                divisor_d = dvs_abs;
                rq_d      = {{W{1'b0}}, dvd_abs};
                q_neg_d   = dividend_q[W-1] ^ divisor_q[W-1];
                r_neg_d   = dividend_q[W-1];
                cnt_d     = '0;
                if (divisor_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                if (shifted[2*W-1:W] >= divisor_q) begin
                    rq_d = {diff, shifted[W-1:1], 1'b1};
                end else begin
                    rq_d = shifted;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
                dbz_d       = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            rq_q        <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            rq_q        <= rq_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        quotient    = quotient_q;
        remainder   = remainder_q;
        div_by_zero = dbz_q;
    end

endmodule
